// File: rtl/gold_ring_pkg.sv
// Shared definitions for the Cardinal ring router: field defaults, port indices, hop helper.
package gold_ring_pkg;

  localparam int unsigned DEF_PAC_SIZE = 64;
  localparam int unsigned DEF_VC_BIT   = 63;
  localparam int unsigned DEF_DIR_BIT  = 62;
  localparam int unsigned DEF_HOP_LSB  = 48;
  localparam int unsigned DEF_HOP_W    = 8;

  localparam int unsigned CW    = 0;
  localparam int unsigned CCW   = 1;
  localparam int unsigned PE    = 2;
  localparam int unsigned NPORT = 3;

  // One hop consumed; the caller truncates to its own field width
  function automatic logic [31:0] hop_dec(input logic [31:0] hop);
    return hop - 32'd1;
  endfunction

endpackage

// File: rtl/gold_rr_arb2.sv
// Two-requester round-robin arbiter; pointer 0 favours req[0].
module gold_rr_arb2
  import gold_ring_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic ptr;

  // Grant: a lone requester wins outright, contention is resolved by the pointer
  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = ptr ? 2'b10 : 2'b01;
        default: gnt_c = 2'b00;
      endcase
    end
  end

  // Pointer moves only after a contended grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/gold_router_rr.sv
// Cardinal ring router node: cw/ccw/PE ports, two VCs time-multiplexed by polarity.
// Optional statistics counters are enabled with GOLD_ROUTER_STATS_EN.
module gold_router_rr
  import gold_ring_pkg::*;
#(
  parameter int unsigned PAC_SIZE = DEF_PAC_SIZE,
  parameter int unsigned VC_BIT   = DEF_VC_BIT,
  parameter int unsigned DIR_BIT  = DEF_DIR_BIT,
  parameter int unsigned HOP_LSB  = DEF_HOP_LSB,
  parameter int unsigned HOP_W    = DEF_HOP_W
) (
`ifdef GOLD_ROUTER_STATS_EN
  output logic [31:0]         fwd_cnt,
  output logic [31:0]         ej_cnt,
`endif
  input  logic                clk,
  input  logic                reset,
  input  logic                polarity,
  input  logic                cwsi,
  output logic                cwri,
  input  logic [PAC_SIZE-1:0] cwdi,
  input  logic                ccwsi,
  output logic                ccwri,
  input  logic [PAC_SIZE-1:0] ccwdi,
  input  logic                pesi,
  output logic                peri,
  input  logic [PAC_SIZE-1:0] pedi,
  output logic                cwso,
  input  logic                cwro,
  output logic [PAC_SIZE-1:0] cwdo,
  output logic                ccwso,
  input  logic                ccwro,
  output logic [PAC_SIZE-1:0] ccwdo,
  output logic                peso,
  input  logic                pero,
  output logic [PAC_SIZE-1:0] pedo
);

  logic [NPORT-1:0]    si, ro, push, drain;
  logic [PAC_SIZE-1:0] di [NPORT];
  logic                in_full  [NPORT][2];
  logic                out_full [NPORT][2];
  logic [PAC_SIZE-1:0] in_data  [NPORT][2];
  logic [PAC_SIZE-1:0] out_data [NPORT][2];
  logic [1:0]          req      [NPORT][2];
  logic [1:0]          gnt      [NPORT][2];
  logic                pop      [NPORT][2];
  logic [PAC_SIZE-1:0] mv_data  [NPORT][2];

  assign si = {pesi, ccwsi, cwsi};
  assign ro = {pero, ccwro, cwro};
  assign di[CW]  = cwdi;
  assign di[CCW] = ccwdi;
  assign di[PE]  = pedi;

  assign cwri  = ~in_full[CW][polarity];
  assign ccwri = ~in_full[CCW][polarity];
  assign peri  = ~in_full[PE][polarity];
  assign cwso  = out_full[CW][polarity];
  assign ccwso = out_full[CCW][polarity];
  assign peso  = out_full[PE][polarity];
  assign cwdo  = out_data[CW][polarity];
  assign ccwdo = out_data[CCW][polarity];
  assign pedo  = out_data[PE][polarity];

  // Routing, arbitration and move selection per VC; only the VC opposite polarity moves
  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic                cw_hz, ccw_hz, pe_dir;
    logic [PAC_SIZE-1:0] cw_fwd, ccw_fwd;

    assign cw_hz  = (in_data[CW][v][HOP_LSB +: HOP_W] == '0);
    assign ccw_hz = (in_data[CCW][v][HOP_LSB +: HOP_W] == '0);
    assign pe_dir = in_data[PE][v][DIR_BIT];

    // Forwarded link packets carry one hop fewer
    always_comb begin
      cw_fwd  = in_data[CW][v];
      ccw_fwd = in_data[CCW][v];
      cw_fwd[HOP_LSB +: HOP_W]  = HOP_W'(hop_dec(32'(in_data[CW][v][HOP_LSB +: HOP_W])));
      ccw_fwd[HOP_LSB +: HOP_W] = HOP_W'(hop_dec(32'(in_data[CCW][v][HOP_LSB +: HOP_W])));
    end

    assign req[CW][v]  = {in_full[PE][v] & ~pe_dir, in_full[CW][v] & ~cw_hz};
    assign req[CCW][v] = {in_full[PE][v] & pe_dir, in_full[CCW][v] & ~ccw_hz};
    assign req[PE][v]  = {in_full[CCW][v] & ccw_hz, in_full[CW][v] & cw_hz};

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
      gold_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (~out_full[o][v] & (polarity != 1'(v))),
        .req   (req[o][v]),
        .gnt_c (gnt[o][v])
      );
    end

    assign mv_data[CW][v]  = gnt[CW][v][0]  ? cw_fwd         : in_data[PE][v];
    assign mv_data[CCW][v] = gnt[CCW][v][0] ? ccw_fwd        : in_data[PE][v];
    assign mv_data[PE][v]  = gnt[PE][v][0]  ? in_data[CW][v] : in_data[CCW][v];

    assign pop[CW][v]  = gnt[CW][v][0]  | gnt[PE][v][0];
    assign pop[CCW][v] = gnt[CCW][v][0] | gnt[PE][v][1];
    assign pop[PE][v]  = gnt[CW][v][1]  | gnt[CCW][v][1];
  end

  // Per-port, per-VC single-entry input and output buffers
  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign push[i]  = si[i] & ~in_full[i][polarity] & (di[i][VC_BIT] == polarity);
    assign drain[i] = out_full[i][polarity] & ro[i];

    for (genvar v = 0; v < 2; v++) begin : g_buf
      logic                in_full_r, out_full_r, ext;
      logic [PAC_SIZE-1:0] in_data_r, out_data_r;

      assign ext = (polarity == 1'(v));

      // Input buffer: filled by the external handshake, emptied by an internal move
      always_ff @(posedge clk) begin
        if (reset) begin
          in_full_r <= 1'b0;
          in_data_r <= '0;
        end else if (ext) begin
          if (push[i]) begin
            in_full_r <= 1'b1;
            in_data_r <= di[i];
          end
        end else if (pop[i][v]) begin
          in_full_r <= 1'b0;
        end
      end

      // Output buffer: filled by an internal move, emptied by the external handshake
      always_ff @(posedge clk) begin
        if (reset) begin
          out_full_r <= 1'b0;
          out_data_r <= '0;
        end else if (ext) begin
          if (drain[i]) out_full_r <= 1'b0;
        end else if (|gnt[i][v]) begin
          out_full_r <= 1'b1;
          out_data_r <= mv_data[i][v];
        end
      end

      assign in_full[i][v]  = in_full_r;
      assign in_data[i][v]  = in_data_r;
      assign out_full[i][v] = out_full_r;
      assign out_data[i][v] = out_data_r;
    end
  end

`ifdef GOLD_ROUTER_STATS_EN
  logic [1:0] fwd_inc;

  assign fwd_inc = {1'b0, gnt[CW][0][0] | gnt[CW][1][0]} + {1'b0, gnt[CCW][0][0] | gnt[CCW][1][0]};

  // Wrap-around link-forward and PE-ejection counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt <= '0;
      ej_cnt  <= '0;
    end else begin
      fwd_cnt <= fwd_cnt + 32'(fwd_inc);
      ej_cnt  <= ej_cnt + 32'(drain[PE]);
    end
  end
`endif

endmodule

// File: doc/gold_router_rr.md
Name: gold_router_rr

Overview:
- Parametrised next-generation router for the Cardinal bidirectional ring; one instance per node.
- Handles cw, ccw and PE ports, each with two virtual channels (VC0/VC1) time-multiplexed by the global polarity bit.
- Adds a hop-count routing field, so ring size is unrestricted, and per-output round-robin arbitration.

Parameters:
- PAC_SIZE, 64, packet width.
- VC_BIT, 63, packet bit selecting VC.
- DIR_BIT, 62, packet bit selecting direction: 0 = cw, 1 = ccw.
- HOP_LSB, 48, LSB of the hop-count field.
- HOP_W, 8, hop-count field width; sets ring size limit 2^HOP_W+1.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- polarity  in  1  global phase; 0 = even cycle, 1 = odd cycle
- cwsi, cwri / cwdi  in,out / in  1,1 / PAC_SIZE  cw input link: send, ready, data
- ccwsi, ccwri / ccwdi  in,out / in  1,1 / PAC_SIZE  ccw input link
- pesi, peri / pedi  in,out / in  1,1 / PAC_SIZE  PE injection
- cwso, cwro / cwdo  out,in / out  1,1 / PAC_SIZE  cw output link: send, ready, data
- ccwso, ccwro / ccwdo  out,in / out  1,1 / PAC_SIZE  ccw output link
- peso, pero / pedo  out,in / out  1,1 / PAC_SIZE  PE ejection

Behaviour:
- Interface: reset is synchronous active-high; clock clk.
- Storage: 6 input buffers (cw, ccw, pe × VC) and 6 output buffers (cw, ccw, pe × VC), 1 entry each, each with a full flag.
- Reset: all full flags 0; all *so = 0; all *do = 0; all round-robin pointers = 0.
- Let p = polarity.
- External phase, VC p:
  - *ri = ~full of input buffer [port][p].
  - Transfer on *si & *ri: store di, set full.
  - A packet whose VC_BIT ≠ p at transfer is dropped. The sender guarantees this never happens.
  - *so = full of output buffer [port][p]; *do = its data.
  - On *so & *ro, clear full. *do holds value when not consumed.
- Internal phase, VC ~p (same cycle): move input buffers of VC ~p to output buffers of VC ~p.
- Routing:
  - Link input with hop == 0: goes to PE output.
  - Link input with hop ≠ 0: forwarded same direction, hop field decremented by 1 (modulo 2^HOP_W is unreachable).
  - PE input: goes to cw output if DIR_BIT = 0, else ccw. Hop not decremented on injection.
  - PE encodes hop = distance − 1.
- Contention and arbitration:
  - cw output: cw input vs PE input.
  - ccw output: ccw input vs PE input.
  - PE output: cw input vs ccw input.
  - Move only if the target output buffer is empty at cycle start. No move into a buffer being drained the same cycle.
  - Per output per VC, a 1-bit round-robin pointer; 0 favours the link/cw requester.
  - Pointer toggles only when two requesters contend and one is granted.
  - Loser keeps its buffer, no data loss.
- Latency, unloaded:
  - Link in → link out: 2 cycles.
  - Ready → data visible downstream: 2 cycles, so each hop costs one full polarity period.
- Reset mid-operation: all packets in flight are discarded, no output asserted the following cycle.

Optional Feature:
- Macro GOLD_ROUTER_STATS_EN.
- When defined:
  - Adds output fwd_cnt [31:0], incremented on each link-to-link forward.
  - Adds output ej_cnt [31:0], incremented on each PE ejection.
  - Both are wrap-around counters, reset to 0.
- When undefined: ports absent, no counter logic.

Decomposition:
- Shared package gold_ring_pkg holds:
  - VC_BIT/DIR_BIT/HOP_LSB/HOP_W defaults.
  - Port index constants: CW = 0, CCW = 1, PE = 2.
  - Helper function hop_dec.
- One sub-module gold_rr_arb2: 2-requester round-robin arbiter with grant and pointer update, instantiated 6×.

Test Plan:
1. Reset held 3 cycles, then released → all *so = 0, all *ri = 1 in matching phase; pointers 0.
2. PE injects 0x0000_0000_0000_00AA, VC0, dir cw, hop 0, in polarity 0 → cwso = 1 two cycles later with identical data, hop = 0.
3. Hand-fed cw input, VC1, hop 2 → forwarded on cwdo with hop 1; same packet fed with hop 0 → appears on pedo, cwso stays 0.
4. Simultaneous cw hop-0 and ccw hop-0 packets on VC0, pero = 1:
   - cw ejected first, ccw ejected 2 cycles later.
   - Repeat → ccw ejected first (pointer toggled).
5. cwro held 0 for 6 cycles with cw output full → cwso/cwdo stable; cwri deasserts once input buffer fills; no packet lost after cwro returns 1.
6. Reset asserted while 3 packets are buffered → next cycle all *so = 0; with GOLD_ROUTER_STATS_EN, fwd_cnt = ej_cnt = 0.
